// File: rtl/fpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fpu_ctrl_pkg
// Brief    : Shared op codes, scheduler state encoding and index helpers for
//            the shared-fpu scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] DROP  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  // Requester indices are carried in 3 bits, enough for up to 8 requesters.
  localparam int IDX_W = 3;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] last);
    return (idx == last) ? '0 : idx + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or above the
//            pointer, otherwise the lowest request overall.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import fpu_ctrl_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [NREQ-1:0]  w_hi_req;
  logic [IDX_W-1:0] w_hi_idx;
  logic [IDX_W-1:0] w_lo_idx;

  always_comb begin
    w_hi_req = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_hi_req[k] = i_req[k] && (IDX_W'(k) >= i_ptr);
    end
  end

  // Two priority encoders; the masked one wins so the search wraps at ptr.
  always_comb begin
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_hi_req[k]) w_hi_idx = IDX_W'(k);
      if (i_req[k])    w_lo_idx = IDX_W'(k);
    end
  end

  always_comb begin
    o_any = |i_req;
    o_idx = (|w_hi_req) ? w_hi_idx : w_lo_idx;
    o_grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_grant[k] = o_any && (o_idx == IDX_W'(k));
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fpu_rr_scheduler
// Brief    : Shares one start/done fpu among NREQ requesters with round-robin
//            arbitration, operand capture, done tracking and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_rr_scheduler
  import fpu_ctrl_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int TO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_op,
  output logic [NREQ-1:0]      ack,
  output logic [31:0]          rsp_r,
  output logic                 err,
  output logic                 busy,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic [1:0]           fpu_op,
  output logic                 fpu_start,
  input  logic                 fpu_done,
  input  logic [31:0]          fpu_r
);

  localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(NREQ - 1);
  localparam logic [7:0]       C_TO_LAST = 8'(TO_CYC - 1);

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gidx;
  logic [7:0]       r_timer;
  logic [NREQ-1:0]  r_ack;
  logic             r_err;
  logic             r_start;
  logic [31:0]      r_rsp;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [1:0]       r_op;

  logic [NREQ-1:0]  w_grant;
  logic [IDX_W-1:0] w_gidx;
  logic             w_any;
  logic [31:0]      w_sel_a;
  logic [31:0]      w_sel_b;
  logic [1:0]       w_sel_op;
  logic [NREQ-1:0]  w_ack_vec;
  logic             w_timeout;
  logic             w_done_hit;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_a  = req_a[32*k +: 32];
        w_sel_b  = req_b[32*k +: 32];
        w_sel_op = req_op[2*k +: 2];
      end
    end
  end

  always_comb begin
    w_ack_vec = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_ack_vec[k] = (r_gidx == IDX_W'(k));
    end
  end

  // The timer's next value reaching TO_CYC ends the wait, so the timeout ack
  // lands exactly TO_CYC cycles after DROP entry. A done seen in WAIT wins.
  assign w_timeout  = (r_timer >= C_TO_LAST);
  assign w_done_hit = (r_state == WAIT) && fpu_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gidx  <= '0;
      r_timer <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_rsp   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_gidx  <= w_gidx;
            r_start <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_timer <= '0;
          r_state <= DROP;
        end
        DROP, WAIT: begin
          if (w_done_hit) begin
            r_rsp   <= fpu_r;
            r_err   <= 1'b0;
            r_ack   <= w_ack_vec;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_rsp   <= '0;
            r_err   <= 1'b1;
            r_ack   <= w_ack_vec;
            r_state <= RESP;
          end else begin
            // A stale done left over from the previous op must fall first.
            if (r_state == DROP && !fpu_done) r_state <= WAIT;
            if (r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
          end
        end
        RESP: begin
          r_err   <= 1'b0;
          r_ptr   <= rr_next(r_gidx, C_LAST);
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign err       = r_err;
  assign rsp_r     = r_rsp;
  assign busy      = (r_state != IDLE);
  assign fpu_a     = r_a;
  assign fpu_b     = r_b;
  assign fpu_op    = r_op;
  assign fpu_start = r_start;

endmodule
`default_nettype wire

// File: tb/tb_fpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_rr_scheduler
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            against a round-robin/fpu reference model; fpu stub with
//            programmable done lag, latency and hang mode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_rr_scheduler;

  localparam int NREQ   = 4;
  localparam int TO_CYC = 16;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [2*NREQ-1:0]   req_op;
  logic [NREQ-1:0]     ack;
  logic [31:0]         rsp_r;
  logic                err;
  logic                busy;
  logic [31:0]         fpu_a;
  logic [31:0]         fpu_b;
  logic [1:0]          fpu_op;
  logic                fpu_start;
  logic                fpu_done;
  logic [31:0]         fpu_r;

  int n_pass  = 0;
  int n_total = 0;

  fpu_rr_scheduler #(
    .NREQ   (NREQ),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .ack       (ack),
    .rsp_r     (rsp_r),
    .err       (err),
    .busy      (busy),
    .fpu_a     (fpu_a),
    .fpu_b     (fpu_b),
    .fpu_op    (fpu_op),
    .fpu_start (fpu_start),
    .fpu_done  (fpu_done),
    .fpu_r     (fpu_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- single-precision arithmetic via real ----------------
  function automatic real sp_to_real(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    real ra, rb;
    ra = sp_to_real(a);
    rb = sp_to_real(b);
    case (op)
      2'b00:   return real_to_sp(ra + rb);
      2'b01:   return real_to_sp(ra - rb);
      2'b10:   return real_to_sp(ra * rb);
      default: return real_to_sp(ra / rb);
    endcase
  endfunction

  // ---------------- fpu stub ----------------
  int          stub_lag   = 0;
  int          stub_delay = 1;
  logic        stub_never = 1'b0;
  logic        st_start_d;
  int          st_phase;
  int          st_cnt;
  logic [31:0] st_a, st_b;
  logic [1:0]  st_op;

  always @(posedge clk) begin
    if (rst) begin
      fpu_done   <= 1'b0;
      fpu_r      <= 32'd0;
      st_start_d <= 1'b0;
      st_phase   <= 0;
      st_cnt     <= 0;
    end else begin
      st_start_d <= fpu_start;
      if (fpu_start && !st_start_d) begin
        st_phase <= 1;
        st_cnt   <= stub_lag;
        st_a     <= fpu_a;
        st_b     <= fpu_b;
        st_op    <= fpu_op;
      end else if (st_phase == 1) begin
        if (st_cnt == 0) begin
          fpu_done <= 1'b0;
          st_phase <= 2;
          st_cnt   <= stub_delay;
        end else st_cnt <= st_cnt - 1;
      end else if (st_phase == 2 && !stub_never) begin
        if (st_cnt == 0) begin
          fpu_done <= 1'b1;
          fpu_r    <= fpu_calc(st_a, st_b, st_op);
          st_phase <= 0;
        end else st_cnt <= st_cnt - 1;
      end
    end
  end

  // ---------------- reference round-robin ----------------
  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    int c;
    for (int k = 0; k < NREQ; k++) begin
      c = (p + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  logic [31:0] ftab [8] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h3f000000,
                            32'h40800000, 32'hbfc00000, 32'h3fa00000, 32'h41000000};

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
    req_op[i*2 +: 2]  = op;
    req[i]            = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output int k, output int gi,
                          output int nstart, output logic to);
    k = 0; gi = -1; nstart = 0; to = 1'b0;
    while (1) begin
      @(negedge clk);
      k++;
      if (fpu_start) nstart++;
      if (ack != '0) begin
        for (int j = 0; j < NREQ; j++) if (ack[j]) gi = j;
        break;
      end
      if (k >= budget) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_total++;
    if ({busy, err, fpu_start} !== 3'b000) $display("FAIL reset_flags: busy/err/start=%b required 000", {busy, err, fpu_start});
    else n_pass++;
    n_total++;
    if (ack !== '0) $display("FAIL reset_ack: got %b required 0", ack);
    else n_pass++;
    n_total++;
    if ({rsp_r, fpu_a, fpu_b, fpu_op} !== 98'd0) $display("FAIL reset_data: rsp=%h a=%h b=%h op=%b required zeros", rsp_r, fpu_a, fpu_b, fpu_op);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || ack !== '0) $display("FAIL reset_idle: busy=%b ack=%b required 0/0", busy, ack);
    else n_pass++;
  endtask

  task automatic test_single();
    int k, gi, ns;
    logic to;
    stub_lag = 0; stub_delay = 2;
    set_req(0, 32'h3f800000, 32'h40000000, 2'b00);
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 0) $display("FAIL single_grant: idx=%0d timeout=%b required idx 0", gi, to);
    else n_pass++;
    n_total++;
    if (rsp_r !== 32'h40400000 || err !== 1'b0) $display("FAIL single_rsp: rsp=%h err=%b required 40400000/0", rsp_r, err);
    else n_pass++;
    n_total++;
    if (k != 7) $display("FAIL single_latency: got %0d cycles required 7", k);
    else n_pass++;
    n_total++;
    if (ns != 1) $display("FAIL single_start: start high %0d cycles required 1", ns);
    else n_pass++;
    req[0] = 1'b0;
    @(negedge clk);
    n_total++;
    if (ack !== '0 || err !== 1'b0 || busy !== 1'b0) $display("FAIL single_pulse: ack=%b err=%b busy=%b required 0/0/0", ack, err, busy);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (rsp_r !== 32'h40400000) $display("FAIL single_hold: rsp=%h required 40400000", rsp_r);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int k, gi, ns, mptr, eg;
    logic to;
    do_reset();
    stub_lag = 0; stub_delay = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h40000000, 32'h40000000, 2'b10);
    mptr = 0;
    for (int n = 0; n < 5; n++) begin
      eg = rr_pick(req, mptr);
      wait_ack(60, k, gi, ns, to);
      n_total++;
      if (to !== 1'b0 || gi != eg || $countones(ack) != 1) $display("FAIL rr_grant%0d: idx=%0d ack=%b required idx %0d", n, gi, ack, eg);
      else n_pass++;
      n_total++;
      if (rsp_r !== 32'h40800000 || err !== 1'b0) $display("FAIL rr_rsp%0d: rsp=%h err=%b required 40800000/0", n, rsp_r, err);
      else n_pass++;
      n_total++;
      if (k != ((n == 0) ? 6 : 7)) $display("FAIL rr_latency%0d: got %0d required %0d", n, k, (n == 0) ? 6 : 7);
      else n_pass++;
      mptr = (eg + 1) % NREQ;
    end
    req = '0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL rr_idle_gap: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_stale_done();
    int k, gi, ns;
    logic to;
    stub_lag = 4; stub_delay = 1;
    set_req(2, 32'h40400000, 32'h3f800000, 2'b01);
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 2) $display("FAIL stale_grant: idx=%0d timeout=%b required 2", gi, to);
    else n_pass++;
    n_total++;
    if (rsp_r !== 32'h40000000 || err !== 1'b0) $display("FAIL stale_rsp: rsp=%h err=%b required 40000000/0", rsp_r, err);
    else n_pass++;
    n_total++;
    if (k != 10) $display("FAIL stale_latency: got %0d required 10", k);
    else n_pass++;
    req[2] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int k, gi, ns;
    logic to;
    stub_lag = 0; stub_delay = 1; stub_never = 1'b1;
    set_req(1, 32'h3f800000, 32'h3f800000, 2'b00);
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 1) $display("FAIL to_grant: idx=%0d timeout=%b required 1", gi, to);
    else n_pass++;
    n_total++;
    if (err !== 1'b1 || rsp_r !== 32'd0) $display("FAIL to_err: err=%b rsp=%h required 1/0", err, rsp_r);
    else n_pass++;
    n_total++;
    if (k != 2 + TO_CYC) $display("FAIL to_latency: got %0d required %0d", k, 2 + TO_CYC);
    else n_pass++;
    req[1] = 1'b0;
    stub_never = 1'b0;
    @(negedge clk);
    n_total++;
    if (err !== 1'b0 || ack !== '0) $display("FAIL to_clear: err=%b ack=%b required 0/0", err, ack);
    else n_pass++;
    set_req(3, 32'h3fa00000, 32'h40800000, 2'b10);
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 3 || rsp_r !== 32'h40a00000 || err !== 1'b0) $display("FAIL to_next: idx=%0d rsp=%h err=%b required 3/40a00000/0", gi, rsp_r, err);
    else n_pass++;
    req[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k, gi, ns, nack;
    logic to;
    stub_lag = 0; stub_delay = 1;
    set_req(1, 32'h3f800000, 32'h3f000000, 2'b11);
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 1 || rsp_r !== 32'h40000000) $display("FAIL rmid_pre: idx=%0d rsp=%h required 1/40000000", gi, rsp_r);
    else n_pass++;
    req[1] = 1'b0;
    @(negedge clk);
    stub_never = 1'b1;
    set_req(2, 32'h40000000, 32'h40000000, 2'b00);
    repeat (6) @(negedge clk);
    n_total++;
    if (busy !== 1'b1) $display("FAIL rmid_busy: busy=%b required 1", busy);
    else n_pass++;
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || ack !== '0 || fpu_start !== 1'b0 || err !== 1'b0 || rsp_r !== 32'd0) $display("FAIL rmid_state: busy=%b ack=%b start=%b err=%b rsp=%h required all 0", busy, ack, fpu_start, err, rsp_r);
    else n_pass++;
    rst = 1'b0;
    stub_never = 1'b0;
    nack = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != '0) nack++;
    end
    n_total++;
    if (nack != 0) $display("FAIL rmid_noack: got %0d acks required 0", nack);
    else n_pass++;
    set_req(3, 32'h40000000, 32'h3f800000, 2'b00);
    set_req(0, 32'h40000000, 32'h3f800000, 2'b01);
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 0 || rsp_r !== 32'h3f800000) $display("FAIL rmid_ptr: idx=%0d rsp=%h required 0/3f800000", gi, rsp_r);
    else n_pass++;
    req[0] = 1'b0;
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 3 || rsp_r !== 32'h40400000) $display("FAIL rmid_next: idx=%0d rsp=%h required 3/40400000", gi, rsp_r);
    else n_pass++;
    req[3] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_operand_hold();
    int k, gi, ns, nack;
    logic to;
    stub_lag = 0; stub_delay = 6;
    set_req(1, 32'h40800000, 32'h40000000, 2'b11);
    repeat (2) @(negedge clk);
    req_a[1*32 +: 32] = 32'h41000000;
    req_op[1*2 +: 2]  = 2'b00;
    set_req(3, 32'h3f800000, 32'h3f800000, 2'b00);
    @(negedge clk);
    req[3] = 1'b0;
    n_total++;
    if (fpu_a !== 32'h40800000 || fpu_op !== 2'b11) $display("FAIL hold_latch: a=%h op=%b required 40800000/11", fpu_a, fpu_op);
    else n_pass++;
    wait_ack(60, k, gi, ns, to);
    n_total++;
    if (to !== 1'b0 || gi != 1 || rsp_r !== 32'h40000000) $display("FAIL hold_rsp: idx=%0d rsp=%h required 1/40000000", gi, rsp_r);
    else n_pass++;
    req[1] = 1'b0;
    nack = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack != '0) nack++;
    end
    n_total++;
    if (nack != 0) $display("FAIL hold_dropped: got %0d acks required 0", nack);
    else n_pass++;
  endtask

  task automatic test_random();
    int k, gi, ns, mptr, eg;
    logic to;
    logic [31:0] exp_r;
    do_reset();
    mptr = 0;
    for (int i = 0; i < NREQ; i++)
      if ($urandom_range(0, 1) == 1)
        set_req(i, ftab[$urandom_range(0, 7)], ftab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)));
    if (req == '0) set_req(2, ftab[1], ftab[2], 2'b10);
    for (int n = 0; n < 40; n++) begin
      stub_lag   = $urandom_range(0, 2);
      stub_delay = $urandom_range(0, 4);
      eg    = rr_pick(req, mptr);
      exp_r = fpu_calc(req_a[eg*32 +: 32], req_b[eg*32 +: 32], req_op[eg*2 +: 2]);
      wait_ack(100, k, gi, ns, to);
      n_total++;
      if (to !== 1'b0 || gi != eg || $countones(ack) != 1) $display("FAIL rand_grant%0d: idx=%0d ack=%b required idx %0d", n, gi, ack, eg);
      else n_pass++;
      n_total++;
      if (rsp_r !== exp_r || err !== 1'b0) $display("FAIL rand_rsp%0d: rsp=%h err=%b required %h/0", n, rsp_r, err, exp_r);
      else n_pass++;
      if (to) return;
      mptr = (eg + 1) % NREQ;
      req[eg] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_req(i, ftab[$urandom_range(0, 7)], ftab[$urandom_range(0, 7)], 2'($urandom_range(0, 3)));
      if (req == '0) set_req($urandom_range(0, NREQ - 1), ftab[0], ftab[4], 2'b11);
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; req_op = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stale_done();
    test_timeout();
    test_reset_mid();
    test_operand_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
